// File: rtl/axi_s_arb.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-Stream sources onto one output.
//   state  | meaning
//   S_IDLE | no grant; picks the next requester after last_grant
//   S_BUSY | grant locked to one source until its tlast beat handshakes
module axi_s_arb #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      m_aclk,
  input  logic                      m_resetn,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_SRC);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_last;

  // Scan starts one past last_grant, so the previous winner is checked last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant_q;
    cand       = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_SRC);
      if (!pick_found && s_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Grant is one-hot or zero, so an and-or mux forces zeros on the outputs in IDLE.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        sel_data  = sel_data | s_tdata[i*DATA_W +: DATA_W];
        sel_valid = sel_valid | s_tvalid[i];
        sel_last  = sel_last | s_tlast[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d      = S_BUSY;
          grant_d      = {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx;
          last_grant_d = pick_idx;
        end
      end
      S_BUSY: begin
        if (sel_valid && m_tready && sel_last) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge m_aclk or negedge m_resetn) begin
    if (!m_resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == S_BUSY);
  assign m_tdata  = sel_data;
  assign m_tvalid = sel_valid;
  assign m_tlast  = sel_last;
  assign s_tready = grant_q & {NUM_SRC{m_tready}};

endmodule

// File: tb/tb_axi_s_arb.sv
// Bench for axi_s_arb: directed packet scenarios and randomized traffic, checked every cycle
// against a behavioural owner/round-robin model and per-source beat scoreboards.
module tb_axi_s_arb;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int OUT_W   = 2*NUM_SRC + DATA_W + 3;

  logic                      m_aclk = 1'b0;
  logic                      m_resetn = 1'b0;
  logic [NUM_SRC*DATA_W-1:0] s_tdata = '0;
  logic [NUM_SRC-1:0]        s_tvalid = '0;
  logic [NUM_SRC-1:0]        s_tlast = '0;
  logic [NUM_SRC-1:0]        s_tready;
  logic [DATA_W-1:0]         m_tdata;
  logic                      m_tvalid;
  logic                      m_tlast;
  logic                      m_tready = 1'b0;
  logic [NUM_SRC-1:0]        grant;
  logic                      busy;

  always #5 m_aclk = ~m_aclk;

  axi_s_arb #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) dut (
    .m_aclk   (m_aclk),
    .m_resetn (m_resetn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .grant    (grant),
    .busy     (busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Beats are {last, data}; src_q feeds the drivers, exp_q is what must come out.
  logic [DATA_W:0]    src_q[NUM_SRC][$];
  logic [DATA_W:0]    exp_q[NUM_SRC][$];
  logic [NUM_SRC-1:0] gap = '0;

  int owner  = -1;
  int last_g = NUM_SRC - 1;

  logic [NUM_SRC-1:0] glog[$];
  logic [NUM_SRC-1:0] prev_grant = '0;
  int                 cnt_busy = 0;
  int                 cnt_beat = 0;
  int                 cnt_vld = 0;
  int                 cnt_srdy1 = 0;
  logic [7:0]         vld_hist = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: owner is the source holding the packet lock, -1 when none.
  always @(posedge m_aclk or negedge m_resetn) begin
    if (!m_resetn) begin
      owner  = -1;
      last_g = NUM_SRC - 1;
    end else if (owner < 0) begin
      for (int k = 1; k <= NUM_SRC; k++)
        if (owner < 0 && s_tvalid[(last_g + k) % NUM_SRC]) owner = (last_g + k) % NUM_SRC;
      if (owner >= 0) last_g = owner;
    end else if (s_tvalid[owner] && m_tready && s_tlast[owner]) begin
      owner = -1;
    end
  end

  always @(negedge m_aclk) begin : compare
    logic [OUT_W-1:0]   e_out;
    logic [OUT_W-1:0]   a_out;
    logic [NUM_SRC-1:0] e_g;
    logic [NUM_SRC-1:0] e_r;
    logic [DATA_W-1:0]  e_d;
    logic               e_v;
    logic               e_l;
    logic [DATA_W:0]    e_beat;
    e_g = '0;
    e_r = '0;
    e_d = '0;
    e_v = 1'b0;
    e_l = 1'b0;
    if (owner >= 0) begin
      e_g[owner] = 1'b1;
      e_r[owner] = m_tready;
      e_d = s_tdata[owner*DATA_W +: DATA_W];
      e_v = s_tvalid[owner];
      e_l = s_tlast[owner];
    end
    e_out = {e_g, owner >= 0, e_v, e_l, e_d, e_r};
    a_out = {grant, busy, m_tvalid, m_tlast, m_tdata, s_tready};
    chk("cycle_outputs", a_out, e_out);

    if (owner >= 0 && m_tvalid && m_tready) begin
      chk("sb_beat_expected", exp_q[owner].size() > 0, 1);
      if (exp_q[owner].size() > 0) begin
        e_beat = exp_q[owner].pop_front();
        chk("sb_beat", {m_tlast, m_tdata}, e_beat);
      end
    end

    if (busy) cnt_busy++;
    if (m_tvalid && m_tready) cnt_beat++;
    if (m_tvalid) cnt_vld++;
    if (s_tready[1]) cnt_srdy1++;
    vld_hist = {vld_hist[6:0], m_tvalid};
    if (grant != '0 && prev_grant == '0) glog.push_back(grant);
    prev_grant = grant;
  end

  task automatic apply();
    logic [DATA_W:0] b;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_q[i].size() > 0 && !gap[i]) begin
        b = src_q[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[i*DATA_W +: DATA_W] = b[DATA_W-1:0];
        s_tlast[i] = b[DATA_W];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        s_tlast[i] = 1'($urandom);
      end
    end
  endtask

  // One clock: present inputs, note handshakes mid-cycle, retire them after the edge.
  task automatic step();
    logic [NUM_SRC-1:0] hs;
    apply();
    @(negedge m_aclk);
    hs = s_tvalid & s_tready;
    @(posedge m_aclk);
    #1;
    for (int i = 0; i < NUM_SRC; i++)
      if (hs[i]) void'(src_q[i].pop_front());
  endtask

  task automatic push_pkt(input int src, input int len);
    logic [DATA_W:0] b;
    for (int j = 0; j < len; j++) begin
      b = {j == len - 1, DATA_W'($urandom)};
      src_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM_SRC; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    gap = '0;
    m_tready = 1'b1;
    while ((pending() > 0 || owner >= 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", pending(), 0);
  endtask

  // Called just after a rising edge; reset lands mid-cycle and releases after the next edge.
  task automatic reset_pulse();
    #2;
    m_resetn = 1'b0;
    #1;
    chk("async_reset_outputs", {grant, busy, m_tvalid, m_tlast, m_tdata, s_tready}, '0);
    for (int i = 0; i < NUM_SRC; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    apply();
    @(posedge m_aclk);
    #1;
    m_resetn = 1'b1;
  endtask

  task automatic chk_glog(input string nm, input logic [NUM_SRC-1:0] e[$]);
    chk({nm, "_count"}, glog.size(), e.size());
    for (int k = 0; k < e.size() && k < glog.size(); k++) chk(nm, glog[k], e[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1);
  end

  initial begin
    logic [NUM_SRC-1:0] eq[$];
    repeat (3) @(posedge m_aclk);
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_m_tvalid", m_tvalid, 0);
    chk("reset_s_tready", s_tready, 0);
    m_resetn = 1'b1;
    m_tready = 1'b1;

    // All four sources with 3-beat packets, source 0 twice: 5 packets, 3 busy cycles each.
    glog.delete();
    cnt_busy = 0;
    for (int s = 0; s < NUM_SRC; s++) push_pkt(s, 3);
    push_pkt(0, 3);
    drain(100);
    eq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk_glog("rr_order", eq);
    chk("rr_busy_cycles", cnt_busy, 15);

    // Source 2 locked mid-packet; 0 and 3 arrive late, 3 is next after 2.
    glog.delete();
    push_pkt(2, 4);
    step();
    step();
    push_pkt(0, 2);
    push_pkt(3, 2);
    drain(100);
    eq = '{4'b0100, 4'b1000, 4'b0001};
    chk_glog("lock_order", eq);

    // 4-beat packet from source 1 with m_tready alternating 1,0,...: beats on even cycles.
    glog.delete();
    push_pkt(1, 4);
    step();
    cnt_busy = 0;
    cnt_beat = 0;
    for (int k = 0; k < 8; k++) begin
      m_tready = (k % 2 == 0);
      step();
    end
    m_tready = 1'b1;
    chk("bp_beats", cnt_beat, 4);
    chk("bp_busy_cycles", cnt_busy, 7);
    eq = '{4'b0010};
    chk_glog("bp_grant", eq);
    drain(20);

    // Source 3 alone with single-beat packets: valid every other cycle.
    glog.delete();
    cnt_busy = 0;
    vld_hist = '0;
    repeat (3) push_pkt(3, 1);
    repeat (6) step();
    chk("single_vld_pattern", vld_hist[5:0], 6'b010101);
    chk("single_busy_cycles", cnt_busy, 3);
    eq = '{4'b1000, 4'b1000, 4'b1000};
    chk_glog("single_grant", eq);

    // Reset during beat 2 of a source-1 packet; afterwards source 0 has priority.
    push_pkt(1, 4);
    step();
    step();
    reset_pulse();
    glog.delete();
    push_pkt(1, 2);
    push_pkt(0, 2);
    drain(50);
    eq = '{4'b0001, 4'b0010};
    chk_glog("post_reset_order", eq);

    // Source 0 pauses for 3 cycles mid-packet while source 1 waits.
    glog.delete();
    push_pkt(0, 5);
    push_pkt(1, 2);
    step();
    step();
    step();
    gap[0] = 1'b1;
    cnt_vld = 0;
    cnt_srdy1 = 0;
    cnt_busy = 0;
    repeat (3) step();
    gap[0] = 1'b0;
    chk("pause_m_tvalid", cnt_vld, 0);
    chk("pause_s_tready1", cnt_srdy1, 0);
    chk("pause_busy_cycles", cnt_busy, 3);
    drain(50);
    eq = '{4'b0001, 4'b0010};
    chk_glog("pause_order", eq);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_q[i].size() < 6 && $urandom_range(0, 9) == 0) push_pkt(i, $urandom_range(1, 4));
        gap[i] = ($urandom_range(0, 3) == 0);
      end
      m_tready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 599) == 0) reset_pulse();
      else step();
    end
    drain(400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
